// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: opcodes, FSM states, ALU op codes and ALU helpers for mc_cpu.
package mc_cpu_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b, OP_HALT = 6'h3f;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT
  } state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  function automatic logic funct_ok(input logic [5:0] fn);
    return fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
  endfunction
  function automatic alu_op_e funct_op(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
           fn == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    return op == ALU_SUB ? a - b : op == ALU_AND ? a & b : op == ALU_OR ? a | b :
           op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
  endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: register file with two async read ports, one sync write port, $0 hardwired to zero.
module mc_regfile #(
  parameter int NREGS_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [NREGS_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [NREGS_LOG2-1:0] raddr_a_i,
  input  logic [NREGS_LOG2-1:0] raddr_b_i,
  output logic [31:0]           rdata_a_o,
  output logic [31:0]           rdata_b_o
);
  logic [31:0] regs_q [2**NREGS_LOG2];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 2**NREGS_LOG2; i++) regs_q[i] <= '0;
    else if (we_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
  assign rdata_a_o = raddr_a_i == '0 ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = raddr_b_i == '0 ? '0 : regs_q[raddr_b_i];
endmodule

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core with one shared ALU and a single req/ready memory port.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          NREGS_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       dout,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       dbg_pc
);
  state_e state_q, dec_state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, dout_q;
  logic illegal_q;
  logic [31:0] simm, rd_a, rd_b, alu_a, alu_b, alu_y, rf_wdata;
  logic [5:0] op, fn;
  logic taken, rf_we;
  logic [NREGS_LOG2-1:0] rf_waddr;
  alu_op_e alu_op;
  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign simm = {{16{ir_q[15]}}, ir_q[15:0]};
  // The single ALU computes PC+4 in FETCH and the branch target in DECODE.
  assign alu_a = (state_q == FETCH || state_q == DECODE) ? pc_q : a_q;
  assign alu_b = state_q == FETCH ? 32'd4 : state_q == DECODE ? {simm[29:0], 2'b00} :
                 state_q == EXEC_R ? b_q : simm;
  assign alu_op = state_q == EXEC_R ? funct_op(fn) : ALU_ADD;
  assign alu_y = alu(alu_op, alu_a, alu_b);
  assign taken = op == OP_BEQ ? a_q == b_q : !a_q[31] && a_q != '0;
  assign dec_state_d = op == OP_R ? (funct_ok(fn) ? EXEC_R : HALT) :
                       op == OP_ADDI ? EXEC_I :
                       (op == OP_LW || op == OP_SW) ? MEM_ADDR :
                       (op == OP_BEQ || op == OP_BGTZ) ? BRANCH :
                       op == OP_J ? JUMP : HALT;
  assign rf_we = state_q == WB_ALU || state_q == WB_MEM;
  assign rf_waddr = (state_q == WB_ALU && op == OP_R) ? ir_q[11 +: NREGS_LOG2] : ir_q[16 +: NREGS_LOG2];
  assign rf_wdata = state_q == WB_MEM ? mdr_q : alu_q;
  assign mem_req = !rst && (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR);
  assign mem_we = !rst && state_q == MEM_WR;
  assign mem_addr = {state_q == FETCH ? pc_q[ADDR_W-1:2] : alu_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = b_q;
  assign dout = dout_q;
  assign halted = state_q == HALT;
  assign illegal = illegal_q;
  assign dbg_pc = pc_q;
  mc_regfile #(.NREGS_LOG2(NREGS_LOG2)) u_rf (
    .clk(clk), .rst(rst), .we_i(rf_we), .waddr_i(rf_waddr), .wdata_i(rf_wdata),
    .raddr_a_i(ir_q[21 +: NREGS_LOG2]), .raddr_b_i(ir_q[16 +: NREGS_LOG2]),
    .rdata_a_o(rd_a), .rdata_b_o(rd_b)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      dout_q <= '0;
      illegal_q <= 1'b0;
    end else
      case (state_q)
        FETCH: if (mem_ready) begin
          ir_q <= mem_rdata;
          pc_q <= alu_y;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
          alu_q <= alu_y;
          illegal_q <= dec_state_d == HALT && op != OP_HALT;
          state_q <= dec_state_d;
        end
        EXEC_R, EXEC_I: begin
          alu_q <= alu_y;
          state_q <= WB_ALU;
        end
        WB_ALU: begin
          dout_q <= alu_q;
          state_q <= FETCH;
        end
        MEM_ADDR: begin
          alu_q <= alu_y;
          state_q <= op == OP_LW ? MEM_RD : MEM_WR;
        end
        MEM_RD: if (mem_ready) begin
          mdr_q <= mem_rdata;
          state_q <= WB_MEM;
        end
        WB_MEM: begin
          dout_q <= mdr_q;
          state_q <= FETCH;
        end
        MEM_WR: if (mem_ready) state_q <= FETCH;
        BRANCH: begin
          if (taken) pc_q <= alu_q;
          state_q <= FETCH;
        end
        JUMP: begin
          pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
          state_q <= FETCH;
        end
        default: state_q <= HALT;
      endcase
endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: scoreboard bench for mc_cpu; a wait-state memory model checks every completed transfer and dout update.
module tb_mc_cpu;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic mem_req, mem_we, halted, illegal;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata, dout, dbg_pc;
  logic [31:0] mem [1024];
  typedef struct packed {logic we; logic [11:0] addr; logic [31:0] data;} txn_t;
  txn_t tq[$];
  logic [31:0] dq[$];
  int tcyc[$];
  int total = 0, bad = 0, cyc = 0, t0 = 0, wcnt = 0, need = 0, stall_n = 0;
  logic [11:0] stall_addr = '0;
  logic pend = 1'b0;
  txn_t e, lat, cur;
  logic [31:0] prev_dout = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[11:2]];

  mc_cpu #(.ADDR_W(12), .RESET_PC(32'h0), .NREGS_LOG2(5)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dout(dout),
    .halted(halted), .illegal(illegal), .dbg_pc(dbg_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model and monitor: wait states, scoreboard pops, handshake stability, dout updates.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b0;
      wcnt = 0;
      pend = 1'b0;
    end else begin
      if (mem_req) begin
        cur = '{we: mem_we, addr: mem_addr, data: mem_wdata};
        if (pend) chk("hold_stable", cur, lat);
        pend = 1'b1;
        lat = cur;
        need = (mem_addr == stall_addr) ? stall_n : 0;
        if (wcnt >= need) begin
          mem_ready = 1'b1;
          wcnt = 0;
          pend = 1'b0;
          tcyc.push_back(cyc);
          if (tq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL txn: unexpected we=%b addr=%h", mem_we, mem_addr);
          end else begin
            e = tq.pop_front();
            chk("txn_we", mem_we, e.we);
            chk("txn_addr", mem_addr, e.addr);
            if (e.we) chk("txn_wdata", mem_wdata, e.data);
          end
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
      if (halted) chk("req_after_halt", mem_req, 1'b0);
      if (dout !== prev_dout) begin
        if (dq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dout: unexpected update got %h", dout);
        end else chk("dout", dout, dq.pop_front());
      end
    end
    prev_dout = dout;
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask
  task automatic put(input logic [11:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask
  task automatic fetch(input logic [11:0] a);
    tq.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask
  task automatic store(input logic [11:0] a, input logic [31:0] d);
    tq.push_back('{we: 1'b1, addr: a, data: d});
  endtask
  task automatic reset_dut();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_pc", dbg_pc, 32'h0);
    tcyc.delete();
    rst = 1'b0;
    t0 = cyc;
  endtask
  task automatic wait_halt(input int lat_exp);
    for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
    chk("halted", halted, 1'b1);
    chk("halt_latency", cyc - t0, lat_exp);
  endtask
  task automatic end_phase();
    chk("txq_empty", tq.size(), 0);
    chk("doutq_empty", dq.size(), 0);
  endtask

  initial begin
    // Phase 1: zero-wait ALU program ending in halt.
    clear_mem();
    put(12'h00, 32'h20010005); put(12'h04, 32'h2002FFFD); put(12'h08, 32'h00221820);
    put(12'h0C, 32'h00222022); put(12'h10, 32'h00222824); put(12'h14, 32'h00223025);
    put(12'h18, 32'h0041382A); put(12'h1C, 32'h0022402A); put(12'h20, 32'hFC000000);
    for (int a = 0; a <= 32; a += 4) fetch(12'(a));
    dq = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h8, 32'h5, 32'hFFFFFFFD, 32'h1, 32'h0};
    reset_dut();
    wait_halt(34);
    chk("p1_illegal", illegal, 1'b0);
    repeat (5) @(negedge clk);
    end_phase();
    // Phase 2: sw/lw to address 8 with three wait states each.
    clear_mem();
    put(12'h00, 32'h20010005); put(12'h04, 32'h2002FFFD); put(12'h08, 32'h00221820);
    put(12'h0C, 32'hAC030008); put(12'h10, 32'h8C040008); put(12'h14, 32'h00842820);
    put(12'h18, 32'hFC000000);
    stall_addr = 12'h008;
    stall_n = 3;
    fetch(12'h00); fetch(12'h04); fetch(12'h08); fetch(12'h0C); store(12'h008, 32'h2);
    fetch(12'h10); fetch(12'h008); fetch(12'h14); fetch(12'h18);
    dq = '{32'h5, 32'hFFFFFFFD, 32'h2, 32'h4};
    reset_dut();
    wait_halt(36);
    chk("p2_ntxn", tcyc.size(), 9);
    if (tcyc.size() >= 8) begin
      chk("sw_cycles", tcyc[5] - tcyc[3], 7);
      chk("lw_cycles", tcyc[7] - tcyc[5], 8);
    end
    end_phase();
    // Phase 3: bgtz taken / not taken, j, beq self-loop.
    clear_mem();
    stall_n = 0;
    put(12'h00, 32'h20010005); put(12'h04, 32'h1C200002); put(12'h08, 32'hFC000000);
    put(12'h0C, 32'hFC000000); put(12'h10, 32'h08000040); put(12'h100, 32'h2001FFFD);
    put(12'h104, 32'h1C200002); put(12'h108, 32'h1000FFFF);
    fetch(12'h00); fetch(12'h04); fetch(12'h10); fetch(12'h100); fetch(12'h104);
    fetch(12'h108); fetch(12'h108); fetch(12'h108);
    dq = '{32'h5, 32'hFFFFFFFD};
    reset_dut();
    for (int i = 0; i < 200 && tq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("loop_pc", dbg_pc, 32'h10C);
    chk("p3_halted", halted, 1'b0);
    end_phase();
    // Phase 4: illegal opcode 0x3e.
    clear_mem();
    put(12'h00, 32'h20010007); put(12'h04, 32'hF8221820);
    fetch(12'h00); fetch(12'h04);
    dq = '{32'h7};
    reset_dut();
    wait_halt(6);
    chk("p4_illegal", illegal, 1'b1);
    repeat (4) @(negedge clk);
    chk("p4_dout", dout, 32'h7);
    end_phase();
    // Phase 5: reset during a stalled load, then confirm registers were cleared.
    clear_mem();
    put(12'h00, 32'h20020009); put(12'h04, 32'h8C010040);
    stall_addr = 12'h040;
    stall_n = 50;
    fetch(12'h00); fetch(12'h04);
    dq = '{32'h9};
    reset_dut();
    for (int i = 0; i < 100 && !(mem_req && mem_addr == 12'h040); i++) @(negedge clk);
    chk("stall_seen", mem_req && mem_addr == 12'h040, 1'b1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_mid_req", mem_req, 1'b0);
    end_phase();
    clear_mem();
    stall_n = 0;
    put(12'h00, 32'hAC020044); put(12'h04, 32'hFC000000);
    fetch(12'h00); store(12'h044, 32'h0); fetch(12'h04);
    reset_dut();
    wait_halt(6);
    chk("p5_illegal", illegal, 1'b0);
    chk("p5_dout", dout, 32'h0);
    end_phase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
